// File: rtl/char_cursor_ctrl.sv
// Character display cursor/command controller: single-byte commands move a
// saturating cursor, print characters and sweep-clear the framebuffer.
module char_cursor_ctrl #(
  parameter int COL_W  = 5,
  parameter int ROW_W  = 3,
  parameter int CHAR_W = 8,
  parameter logic [CHAR_W-1:0] BLANK = 8'h20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [CHAR_W-1:0]      cmd_char,
  output logic                   fb_we,
  output logic [ROW_W+COL_W-1:0] fb_addr,
  output logic [CHAR_W-1:0]      fb_data,
  output logic [COL_W-1:0]       cur_col,
  output logic [ROW_W-1:0]       cur_row,
  output logic                   busy
);
  localparam int AW = ROW_W + COL_W;

  typedef enum logic {IDLE, CLEAR} state_t;
  typedef enum logic [2:0] {
    OP_PUT, OP_LEFT, OP_RIGHT, OP_UP, OP_DOWN, OP_HOME, OP_NEWLINE, OP_CLEAR
  } op_t;

  state_t            state, stateNext;
  logic [AW:0]       sweepCnt, sweepNext;
  logic [COL_W-1:0]  colNext;
  logic [ROW_W-1:0]  rowNext;
  logic              weNext;
  logic [AW-1:0]     addrNext;
  logic [CHAR_W-1:0] dataNext;
  logic              accept;

  // Extended intermediates: the extra MSB flags overflow (inc) or borrow (dec).
  logic [COL_W:0] colInc, colDec;
  logic [ROW_W:0] rowInc, rowDec;
  logic [COL_W-1:0] colSatInc, colSatDec;
  logic [ROW_W-1:0] rowSatInc, rowSatDec;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == CLEAR);
  assign accept    = cmd_valid & cmd_ready;

  always_comb begin
    colInc    = {1'b0, cur_col} + {{COL_W{1'b0}}, 1'b1};
    colDec    = {1'b0, cur_col} - {{COL_W{1'b0}}, 1'b1};
    rowInc    = {1'b0, cur_row} + {{ROW_W{1'b0}}, 1'b1};
    rowDec    = {1'b0, cur_row} - {{ROW_W{1'b0}}, 1'b1};
    colSatInc = colInc[COL_W] ? cur_col : colInc[COL_W-1:0];
    colSatDec = colDec[COL_W] ? cur_col : colDec[COL_W-1:0];
    rowSatInc = rowInc[ROW_W] ? cur_row : rowInc[ROW_W-1:0];
    rowSatDec = rowDec[ROW_W] ? cur_row : rowDec[ROW_W-1:0];
  end

  always_comb begin
    stateNext = state;
    sweepNext = sweepCnt;
    colNext   = cur_col;
    rowNext   = cur_row;
    weNext    = 1'b0;
    addrNext  = fb_addr;
    dataNext  = fb_data;
    unique case (state)
      IDLE: if (accept) begin
        unique case (op_t'(cmd_op))
          OP_PUT: begin
            weNext   = 1'b1;
            addrNext = {cur_row, cur_col};
            dataNext = cmd_char;
            if (colInc[COL_W]) begin
              colNext = '0;
              rowNext = rowSatInc;
            end else begin
              colNext = colInc[COL_W-1:0];
            end
          end
          OP_LEFT:  colNext = colSatDec;
          OP_RIGHT: colNext = colSatInc;
          OP_UP:    rowNext = rowSatDec;
          OP_DOWN:  rowNext = rowSatInc;
          OP_HOME: begin
            colNext = '0;
            rowNext = '0;
          end
          OP_NEWLINE: begin
            colNext = '0;
            rowNext = rowSatInc;
          end
          OP_CLEAR: begin
            // Write 0 is issued on the accept edge so every busy cycle
            // carries exactly one write; sweepCnt then holds the next address.
            stateNext = CLEAR;
            weNext    = 1'b1;
            addrNext  = '0;
            dataNext  = BLANK;
            sweepNext = {{AW{1'b0}}, 1'b1};
          end
        endcase
      end
      CLEAR: begin
        if (sweepCnt[AW]) begin
          stateNext = IDLE;
          sweepNext = '0;
          colNext   = '0;
          rowNext   = '0;
        end else begin
          weNext    = 1'b1;
          addrNext  = sweepCnt[AW-1:0];
          dataNext  = BLANK;
          sweepNext = sweepCnt + {{AW{1'b0}}, 1'b1};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sweepCnt <= '0;
      cur_col  <= '0;
      cur_row  <= '0;
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_data  <= '0;
    end else begin
      state    <= stateNext;
      sweepCnt <= sweepNext;
      cur_col  <= colNext;
      cur_row  <= rowNext;
      fb_we    <= weNext;
      fb_addr  <= addrNext;
      fb_data  <= dataNext;
    end
  end
endmodule
